// File: rtl/stopwatch_timer_core.sv
// Up/down stopwatch-timer with per-field editing, pause/resume and optional auto-reload.
// Build option: define STOPWATCH_LAP_EN to add the lap input and lap_time capture register.
module stopwatch_timer_core #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int AUTO_RELOAD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_down,
  input  logic        run_toggle,
  input  logic        clear,
  input  logic        inc,
  input  logic        dec,
  input  logic [1:0]  sel_field,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
  output logic [23:0] lap_time,
`endif
  output logic [6:0]  cs,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic [4:0]  hour,
  output logic        running,
  output logic        timeout,
  output logic        done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [6:0]    CS_LAST    = 7'(TICK_HZ - 1);

  // Field layout inside the packed {hour,min,sec,cs} time word.
  localparam int FW   [4] = '{7, 6, 6, 5};
  localparam int FO   [4] = '{0, 7, 13, 19};
  localparam int FMAX [4] = '{TICK_HZ - 1, 59, 59, 23};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t         state_reg;
  logic [PW-1:0]  presc_reg;
  logic [6:0]     cs_reg;
  logic [5:0]     sec_reg;
  logic [5:0]     min_reg;
  logic [4:0]     hour_reg;
  logic [23:0]    preset_reg;
  logic           mode_reg;
  logic           running_reg;
  logic           timeout_reg;
  logic           done_reg;

  logic [23:0]    time_cur;
  logic [23:0]    time_edit;
  logic           edit_en;
  logic           tick;
  logic           expire;
  logic           start_ok;

  logic [6:0] up_cs, dn_cs;
  logic [5:0] up_sec, dn_sec, up_min, dn_min;
  logic [4:0] up_hour, dn_hour;
  logic       dn_zero;

  assign time_cur = {hour_reg, min_reg, sec_reg, cs_reg};
  assign edit_en  = inc ^ dec;
  assign tick     = (state_reg == S_RUN) && (presc_reg == PRESC_LAST);
  assign start_ok = !(mode_down && (time_cur == '0));

  // Selected field steps by one and wraps inside its own range; other fields pass through.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_field
      localparam int W = FW[gi];
      localparam int O = FO[gi];
      localparam logic [W-1:0] LAST = W'(FMAX[gi]);
      logic [W-1:0] v;
      logic [W-1:0] v_inc;
      logic [W-1:0] v_dec;
      assign v     = time_cur[O +: W];
      assign v_inc = (v >= LAST) ? '0 : v + W'(1);
      assign v_dec = (v == '0) ? LAST : v - W'(1);
      assign time_edit[O +: W] = (sel_field != 2'(gi)) ? v :
                                 (inc && !dec)         ? v_inc :
                                 (dec && !inc)         ? v_dec : v;
    end
  endgenerate

  always_comb begin
    up_cs   = cs_reg + 7'd1;
    up_sec  = sec_reg;
    up_min  = min_reg;
    up_hour = hour_reg;
    if (cs_reg >= CS_LAST) begin
      up_cs  = '0;
      up_sec = sec_reg + 6'd1;
      if (sec_reg >= 6'd59) begin
        up_sec = '0;
        up_min = min_reg + 6'd1;
        if (min_reg >= 6'd59) begin
          up_min  = '0;
          up_hour = (hour_reg >= 5'd23) ? 5'd0 : hour_reg + 5'd1;
        end
      end
    end
  end

  always_comb begin
    dn_cs   = cs_reg - 7'd1;
    dn_sec  = sec_reg;
    dn_min  = min_reg;
    dn_hour = hour_reg;
    if (cs_reg == '0) begin
      dn_cs  = CS_LAST;
      dn_sec = sec_reg - 6'd1;
      if (sec_reg == '0) begin
        dn_sec = 6'd59;
        dn_min = min_reg - 6'd1;
        if (min_reg == '0) begin
          dn_min  = 6'd59;
          dn_hour = (hour_reg == '0) ? 5'd23 : hour_reg - 5'd1;
        end
      end
    end
  end

  assign dn_zero = ({dn_hour, dn_min, dn_sec, dn_cs} == '0);
  assign expire  = tick && mode_reg && dn_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      presc_reg   <= '0;
      {hour_reg, min_reg, sec_reg, cs_reg} <= '0;
      preset_reg  <= '0;
      mode_reg    <= 1'b0;
      running_reg <= 1'b0;
      timeout_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      if (clear) begin
        state_reg   <= S_IDLE;
        presc_reg   <= '0;
        {hour_reg, min_reg, sec_reg, cs_reg} <= '0;
        running_reg <= 1'b0;
        done_reg    <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (run_toggle && start_ok) begin
              state_reg   <= S_RUN;
              preset_reg  <= time_cur;
              mode_reg    <= mode_down;
              presc_reg   <= '0;
              running_reg <= 1'b1;
            end else if (edit_en) begin
              {hour_reg, min_reg, sec_reg, cs_reg} <= time_edit;
            end
          end
          S_RUN: begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick) begin
              if (!mode_reg) begin
                {hour_reg, min_reg, sec_reg, cs_reg} <= {up_hour, up_min, up_sec, up_cs};
              end else if (dn_zero && (AUTO_RELOAD != 0)) begin
                {hour_reg, min_reg, sec_reg, cs_reg} <= preset_reg;
              end else begin
                {hour_reg, min_reg, sec_reg, cs_reg} <= {dn_hour, dn_min, dn_sec, dn_cs};
              end
              timeout_reg <= mode_reg && dn_zero;
            end
            // Expiry wins over a coincident pause request.
            if (expire && (AUTO_RELOAD == 0)) begin
              state_reg   <= S_DONE;
              running_reg <= 1'b0;
              done_reg    <= 1'b1;
            end else if (run_toggle) begin
              state_reg   <= S_PAUSE;
              running_reg <= 1'b0;
            end
          end
          S_PAUSE: begin
            if (run_toggle) begin
              state_reg   <= S_RUN;
              running_reg <= 1'b1;
            end else if (edit_en) begin
              {hour_reg, min_reg, sec_reg, cs_reg} <= time_edit;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [23:0] lap_time_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_time_reg <= '0;
    end else if (clear) begin
      lap_time_reg <= '0;
    end else if (lap && (state_reg == S_RUN)) begin
      lap_time_reg <= time_cur;
    end
  end

  assign lap_time = lap_time_reg;
`endif

  assign cs      = cs_reg;
  assign sec     = sec_reg;
  assign min     = min_reg;
  assign hour    = hour_reg;
  assign running = running_reg;
  assign timeout = timeout_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Bench for stopwatch_timer_core: two instances (no reload / auto reload) against a
// time-as-integer reference model, directed scenarios followed by random button traffic.
`timescale 1ns/1ps
module tb_stopwatch_timer_core;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DAY     = 24 * 3600 * TICK_HZ;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_down = 1'b0;
  logic       run_toggle = 1'b0;
  logic       clear = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [1:0] sel_field = 2'd0;
  bit         lp_v = 1'b0;

  logic [6:0] cs0, cs1;
  logic [5:0] sec0, sec1, min0, min1;
  logic [4:0] hour0, hour1;
  logic       running0, running1, timeout0, timeout1, done0, done1;
`ifdef STOPWATCH_LAP_EN
  logic        lap = 1'b0;
  logic [23:0] lap_time0, lap_time1;
`endif

  always #5 clk = ~clk;

  stopwatch_timer_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .rst(rst), .mode_down(mode_down), .run_toggle(run_toggle), .clear(clear),
    .inc(inc), .dec(dec), .sel_field(sel_field),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_time(lap_time0),
`endif
    .cs(cs0), .sec(sec0), .min(min0), .hour(hour0),
    .running(running0), .timeout(timeout0), .done(done0));

  stopwatch_timer_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .rst(rst), .mode_down(mode_down), .run_toggle(run_toggle), .clear(clear),
    .inc(inc), .dec(dec), .sel_field(sel_field),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_time(lap_time1),
`endif
    .cs(cs1), .sec(sec1), .min(min1), .hour(hour1),
    .running(running1), .timeout(timeout1), .done(done1));

  // Reference model: time kept as a single count of ticks since 00:00:00.00.
  typedef struct {
    int st;
    int t;
    int preset;
    int presc;
    bit md;
    bit to;
    int lap_t;
  } mdl_t;

  mdl_t m [2];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_n = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  function automatic logic [23:0] t2p(input int t);
    return {5'(t / (3600 * TICK_HZ)), 6'((t / (60 * TICK_HZ)) % 60),
            6'((t / TICK_HZ) % 60), 7'(t % TICK_HZ)};
  endfunction

  function automatic int mdl_edit(input int t, input int sel, input bit up);
    int f [4];
    int lim [4];
    f[0] = t % TICK_HZ;
    f[1] = (t / TICK_HZ) % 60;
    f[2] = (t / (60 * TICK_HZ)) % 60;
    f[3] = t / (3600 * TICK_HZ);
    lim = '{TICK_HZ, 60, 60, 24};
    f[sel] = (f[sel] + (up ? 1 : lim[sel] - 1)) % lim[sel];
    return ((f[3] * 60 + f[2]) * 60 + f[1]) * TICK_HZ + f[0];
  endfunction

  function automatic mdl_t mdl_step(input mdl_t c, input bit ar, input bit md_in, input bit rt,
                                    input bit clr, input bit in_p, input bit de_p,
                                    input int sel, input bit lp);
    mdl_t n;
    bit   tk;
    n = c;
    n.to = 1'b0;
    tk = (c.st == ST_RUN) && (c.presc == DIV - 1);
    if (clr) begin
      n.st = ST_IDLE; n.t = 0; n.presc = 0; n.lap_t = 0;
      return n;
    end
    case (c.st)
      ST_IDLE: begin
        if (rt && !(md_in && c.t == 0)) begin
          n.st = ST_RUN; n.preset = c.t; n.md = md_in; n.presc = 0;
        end else if (in_p != de_p) begin
          n.t = mdl_edit(c.t, sel, in_p);
        end
      end
      ST_RUN: begin
        n.presc = tk ? 0 : c.presc + 1;
        if (lp) n.lap_t = c.t;
        if (tk) begin
          if (!c.md) n.t = (c.t + 1) % DAY;
          else begin
            n.t = (c.t + DAY - 1) % DAY;
            if (n.t == 0) begin
              n.to = 1'b1;
              if (ar) n.t = c.preset;
              else n.st = ST_DONE;
            end
          end
        end
        if (rt && n.st == ST_RUN) n.st = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (rt) n.st = ST_RUN;
        else if (in_p != de_p) n.t = mdl_edit(c.t, sel, in_p);
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [63:0] mpack(input mdl_t c);
    logic [23:0] lp;
    lp = '0;
`ifdef STOPWATCH_LAP_EN
    lp = t2p(c.lap_t);
`endif
    return {13'b0, lp, t2p(c.t), c.st == ST_RUN, c.to, c.st == ST_DONE};
  endfunction

  function automatic logic [63:0] dpack(input int k);
    logic [23:0] lp;
    lp = '0;
    if (k == 0) begin
`ifdef STOPWATCH_LAP_EN
      lp = lap_time0;
`endif
      return {13'b0, lp, hour0, min0, sec0, cs0, running0, timeout0, done0};
    end
`ifdef STOPWATCH_LAP_EN
    lp = lap_time1;
`endif
    return {13'b0, lp, hour1, min1, sec1, cs1, running1, timeout1, done1};
  endfunction

  task automatic cyc(input bit rt, input bit clr, input bit in_p, input bit de_p);
    run_toggle = rt; clear = clr; inc = in_p; dec = de_p;
`ifdef STOPWATCH_LAP_EN
    lap = lp_v;
`endif
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      m[k] = mdl_step(m[k], k == 1, mode_down, rt, clr, in_p, de_p, int'(sel_field), lp_v);
    #1;
    cyc_n++;
    chk("dut0_state", dpack(0), mpack(m[0]));
    chk("dut1_state", dpack(1), mpack(m[1]));
    if (rt || clr || in_p || de_p || lp_v)
      $display("cyc %0d rt=%0b clr=%0b inc=%0b dec=%0b md=%0b sel=%0d lap=%0b -> %02d:%02d:%02d.%02d run=%0b done=%0b | ar %02d:%02d:%02d.%02d run=%0b",
               cyc_n, rt, clr, in_p, de_p, mode_down, sel_field, lp_v, hour0, min0, sec0, cs0,
               running0, done0, hour1, min1, sec1, cs1, running1);
    run_toggle = 0; clear = 0; inc = 0; dec = 0; lp_v = 0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
  endtask

  task automatic do_reset(input int ncyc);
    #3;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) m[k] = '{default: 0};
    chk("rst_async_dut0", dpack(0), 64'd0);
    chk("rst_async_dut1", dpack(1), 64'd0);
    repeat (ncyc) @(posedge clk);
    #1;
    chk("rst_hold_dut0", dpack(0), 64'd0);
    rst = 1'b1;
    $display("reset held %0d cycles, released", ncyc);
  endtask

  task automatic edit(input int sel, input int n, input bit up);
    sel_field = 2'(sel);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, up, !up);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    int cnt;
    int drops;
    bit found;
    logic [23:0] snap;

    for (int k = 0; k < 2; k++) m[k] = '{default: 0};
    #12;
    chk("reset_dut0", dpack(0), 64'd0);
    chk("reset_dut1", dpack(1), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Down timeout from 00:00:01.00.
    mode_down = 1'b1;
    edit(1, 1, 1'b1);
    cyc(1, 0, 0, 0);
    n = 0; found = 0;
    while (!found && n < 1100) begin
      cyc(0, 0, 0, 0);
      n++;
      if (timeout0) found = 1;
    end
    chk("req33_latency", 64'(n), 64'd1000);
    chk("req33_value", 64'({hour0, min0, sec0, cs0}), 64'd0);
    chk("req33_done", 64'(done0), 64'd1);
    chk("req33_ar_reload", 64'({hour1, min1, sec1, cs1}), 64'(t2p(TICK_HZ)));
    chk("req33_ar_running", 64'(running1), 64'd1);

    // Auto reload every 3 ticks from 00:00:00.03.
    cyc(0, 1, 0, 0);
    edit(0, 3, 1'b1);
    cyc(1, 0, 0, 0);
    last = 0; cnt = 0; drops = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(0, 0, 0, 0);
      if (timeout1) begin
        chk("req35_period", 64'(i - last), 64'(3 * DIV));
        last = i;
        cnt++;
      end
      if (!running1) drops++;
    end
    chk("req35_count", 64'(cnt), 64'd3);
    chk("req35_running", 64'(drops), 64'd0);
    cyc(1, 0, 1, 0);
    chk("done_ignores_buttons", 64'({done0, hour0, min0, sec0, cs0}), {39'd0, 1'b1, 24'd0});

    // Down start from zero is ignored.
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("zero_down_start", 64'({running0, running1}), 64'd0);

    // Up wrap at 23:59:59.99 set while paused.
    mode_down = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int f = 3; f >= 0; f--) edit(f, 1, 1'b0);
    chk("wrap_preset", 64'({hour0, min0, sec0, cs0}), 64'(t2p(DAY - 1)));
    cyc(1, 0, 0, 0);
    n = 0;
    while (n < 20 && {hour0, min0, sec0, cs0} == t2p(DAY - 1)) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("req34_value", 64'({hour0, min0, sec0, cs0}), 64'd0);
    chk("req34_flags", 64'({running0, timeout0}), 64'b10);

    // Clear priority from PAUSE at 00:01:00.00.
    cyc(1, 0, 0, 0);
    edit(2, 1, 1'b1);
    chk("req36_setup", 64'({hour0, min0, sec0, cs0}), 64'(t2p(60 * TICK_HZ)));
    sel_field = 2'd2;
    cyc(1, 1, 1, 0);
    chk("req36_result", 64'({running0, done0, hour0, min0, sec0, cs0}), 64'd0);

    // Field wrap and inc+dec cancellation in IDLE.
    edit(3, 5, 1'b1);
    edit(2, 1, 1'b0);
    chk("req37_min", 64'(min0), 64'd59);
    chk("req37_hour", 64'(hour0), 64'd5);
    snap = {hour0, min0, sec0, cs0};
    cyc(0, 0, 1, 1);
    chk("req37_incdec", 64'({hour0, min0, sec0, cs0}), 64'(snap));

    // Reset in the middle of a down run.
    cyc(0, 1, 0, 0);
    mode_down = 1'b1;
    edit(0, 50, 1'b1);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    chk("req38_before", 64'({running0, hour0, min0, sec0, cs0}), {39'd0, 1'b1, 24'd50});
    do_reset(3);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(0, 0, 0, 0);
      if (timeout0 || timeout1) cnt++;
    end
    chk("req38_no_timeout", 64'(cnt), 64'd0);

    // Random button traffic.
    for (int i = 0; i < 3000; i++) begin
      mode_down = 1'($urandom_range(0, 1));
      sel_field = 2'($urandom_range(0, 3));
      lp_v = ($urandom_range(0, 15) == 0);
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 249) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
